id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the register file.
- Captures the decode-stage bundle each cycle: PC, PC+4, both operand reads, immediate, register indices and control word.
- Applies a write-back bypass so a value written in the same cycle as it is read reaches EX correctly.
- Supports stall (hold) and flush (bubble insertion) driven by the hazard unit.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- REG_AW, 5, register index width.
- CTRL_W, 10, packed control word width: {reg_write, result_src[1:0], mem_write, jump, branch, alu_control[2:0], alu_src}.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- stall_e  in  1  hold all E registers this cycle
- flush_e  in  1  insert bubble into E this cycle
- valid_d  in  1  D holds a real instruction
- pc_d  in  XLEN  D-stage PC
- pc_plus4_d  in  XLEN  D-stage PC+4
- rd1_d  in  XLEN  register file read port 1
- rd2_d  in  XLEN  register file read port 2
- imm_d  in  XLEN  extended immediate
- rs1_d  in  REG_AW  source index 1
- rs2_d  in  REG_AW  source index 2
- rd_d  in  REG_AW  destination index
- ctrl_d  in  CTRL_W  packed control word
- wb_we  in  1  W-stage register write enable (same as regfile we3)
- wb_rd  in  REG_AW  W-stage destination (regfile A3)
- wb_data  in  XLEN  W-stage result (regfile wd3)
- valid_e  out  1  E holds a real instruction
- pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e  out  XLEN  registered copies
- rs1_e, rs2_e, rd_e  out  REG_AW  registered copies
- ctrl_e  out  CTRL_W  registered control word

Behaviour:
- Reset: asynchronous on rst high, independent of clk; every output register goes to 0, including valid_e and ctrl_e. This makes E a bubble.
- Update priority at each posedge clk when rst is low: flush_e, then stall_e, then load.
- Flush: valid_e=0, ctrl_e=0, rd_e=0. Data fields (pc, operands, imm, rs1/rs2) still load from D and are don't-care for checking. Flush overrides a simultaneous stall.
- Stall: every register holds its value, and the bypass is not applied to held values. Upstream must hold the D inputs stable. The hazard unit guarantees no W write targets a stalled E source.
- Load:
  - All fields take their D inputs with latency 1 cycle.
  - valid_e takes valid_d.
  - If valid_d=0, ctrl_e is forced to 0 so an invalid slot can never write state.
- Write-back bypass, applied at load only:
  - rd1_e = wb_data if wb_we && wb_rd!=0 && wb_rd==rs1_d, else rd1_d.
  - The same rule sets rd2_e using rs2_d.
  - Both may bypass in the same cycle.
  - Register x0 is never bypassed: rd1_d passes through, normally 0.
- Pure registers: no arithmetic, no width changes, no combinational path from inputs to outputs.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs bubble_cnt[31:0] and stall_cnt[31:0].
  - bubble_cnt increments on each posedge where the register loads or flushes and the new valid_e is 0.
  - stall_cnt increments on each posedge where stall_e=1 and flush_e=0.
  - Both counters wrap at 2^32 to 0 and reset to 0 on rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run: assert rst between clock edges with E loaded with pc_e=0x40 -> all outputs 0 immediately, before the next edge.
- Plain load: pc_d=0x100, rd1_d=0x11, rd2_d=0x22, ctrl_d=0x3FF, valid_d=1, no stall or flush -> after 1 edge, E outputs equal the inputs and valid_e=1.
- Bypass:
  - rs1_d=5, rs2_d=5, wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, rd1_d=rd2_d=0x0 -> rd1_e=rd2_e=0xDEADBEEF.
  - Repeat with wb_rd=0 and rs1_d=0 -> rd1_e=0.
- Stall then release: load pc_d=0x200; raise stall_e for 3 cycles while pc_d=0x204 -> pc_e stays 0x200; one edge after release, pc_e=0x204.
- Flush over stall: stall_e=1, flush_e=1, ctrl_d=0x3FF -> ctrl_e=0, valid_e=0, rd_e=0. Also valid_d=0 with ctrl_d=0x3FF -> ctrl_e=0.
- With ID_EX_PERF_CNT_EN: sequence of 2 flushes, 3 stalls, 1 load of valid_d=0 -> bubble_cnt=3, stall_cnt=3.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with write-back bypass, stall and flush
// Optional ID_EX_PERF_CNT_EN adds bubble_cnt/stall_cnt performance counters.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              valid_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [CTRL_W-1:0] ctrl_e
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       stall_cnt
`endif
);
  logic [XLEN-1:0] rd1_fwd, rd2_fwd;
  logic            load, valid_n;
  always_comb begin
    rd1_fwd = (wb_we && wb_rd != '0 && wb_rd == rs1_d) ? wb_data : rd1_d;
    rd2_fwd = (wb_we && wb_rd != '0 && wb_rd == rs2_d) ? wb_data : rd2_d;
    load    = flush_e || !stall_e;
    valid_n = valid_d && !flush_e;
  end
  // Flush still loads data fields; only valid, ctrl and rd are forced to a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e    <= 1'b0;
      pc_e       <= '0;
      pc_plus4_e <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      imm_e      <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      ctrl_e     <= '0;
    end else if (load) begin
      valid_e    <= valid_n;
      pc_e       <= pc_d;
      pc_plus4_e <= pc_plus4_d;
      rd1_e      <= rd1_fwd;
      rd2_e      <= rd2_fwd;
      imm_e      <= imm_d;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= flush_e ? '0 : rd_d;
      ctrl_e     <= valid_n ? ctrl_d : '0;
    end
  end
`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (load && !valid_n) bubble_cnt <= bubble_cnt + 32'd1;
      if (stall_e && !flush_e) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule
